via_seq_item_port: RTL and testbench

VIA_SEQ_ITEM_PORT -- requirements
Module: via_seq_item_port

---
 rtl/via_seq_item_port.sv | 159 +++++++++++++++
 tb/tb_via_seq_item_port.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/via_seq_item_port.sv
// Sequencer/driver item port: item FIFO toward the driver plus a single-slot response return path.
// Optional per-item statistics counters: define VIA_SEQ_ITEM_PORT_STATS_EN.
module via_seq_item_port #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ID_W   = 4,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              seq_req_valid,
   output logic              seq_req_ready,
   input  logic [ID_W-1:0]   seq_req_id,
   input  logic [DATA_W-1:0] seq_req_data,
   input  logic              drv_get,
   output logic              drv_item_valid,
   output logic [ID_W-1:0]   drv_item_id,
   output logic [DATA_W-1:0] drv_item_data,
   input  logic              drv_done,
   input  logic [DATA_W-1:0] drv_rsp_data,
   output logic              seq_rsp_valid,
   input  logic              seq_rsp_ready,
   output logic [ID_W-1:0]   seq_rsp_id,
   output logic [DATA_W-1:0] seq_rsp_data,
   output logic              err_protocol
`ifdef VIA_SEQ_ITEM_PORT_STATS_EN
   ,
   output logic [15:0]       items_issued,
   output logic [15:0]       items_done
`endif
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
   } item_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ITEM = 2'd1,
      ACTIVE    = 2'd2,
      RSP_STALL = 2'd3
   } state_t;

   state_t           state;
   item_t            mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;
   logic             violation;
   item_t            head;

   // Ready depends only on the registered occupancy, never on the driver side.
   assign fifo_full     = (count == CNT_W'(DEPTH));
   assign fifo_empty    = (count == '0);
   assign seq_req_ready = ~fifo_full;
   assign push          = seq_req_valid & ~fifo_full;
   assign pop           = ~fifo_empty & ((state == IDLE && drv_get) || state == WAIT_ITEM);
   assign head          = mem[rd_ptr];
   assign violation     = (drv_get && state != IDLE) || (drv_done && state != ACTIVE);

   // Item storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{id: seq_req_id, data: seq_req_data};
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Port FSM with registered item/response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         drv_item_valid <= 1'b0;
         drv_item_id    <= '0;
         drv_item_data  <= '0;
         seq_rsp_valid  <= 1'b0;
         seq_rsp_id     <= '0;
         seq_rsp_data   <= '0;
         err_protocol   <= 1'b0;
      end else begin
         if (violation) err_protocol <= 1'b1;
         case (state)
            IDLE: begin
               if (drv_get) begin
                  if (pop) begin
                     drv_item_valid <= 1'b1;
                     drv_item_id    <= head.id;
                     drv_item_data  <= head.data;
                     state          <= ACTIVE;
                  end else begin
                     state <= WAIT_ITEM;
                  end
               end
            end
            WAIT_ITEM: begin
               if (pop) begin
                  drv_item_valid <= 1'b1;
                  drv_item_id    <= head.id;
                  drv_item_data  <= head.data;
                  state          <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (drv_done) begin
                  drv_item_valid <= 1'b0;
                  seq_rsp_valid  <= 1'b1;
                  seq_rsp_id     <= drv_item_id;
                  seq_rsp_data   <= drv_rsp_data;
                  state          <= RSP_STALL;
               end
            end
            RSP_STALL: begin
               if (seq_rsp_ready) begin
                  seq_rsp_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef VIA_SEQ_ITEM_PORT_STATS_EN
   // Issue/completion counters, free-running with natural 16-bit wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         items_issued <= '0;
         items_done   <= '0;
      end else begin
         if (pop) items_issued <= items_issued + 16'(1);
         if (state == ACTIVE && drv_done) items_done <= items_done + 16'(1);
      end
   end
`endif

endmodule

// File: tb/tb_via_seq_item_port.sv
// Scoreboard bench for via_seq_item_port: directed scenarios plus a randomized push/driver phase.
module tb_via_seq_item_port;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ID_W   = 4;
   localparam int unsigned DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              seq_req_valid = 1'b0;
   logic              seq_req_ready;
   logic [ID_W-1:0]   seq_req_id = '0;
   logic [DATA_W-1:0] seq_req_data = '0;
   logic              drv_get = 1'b0;
   logic              drv_item_valid;
   logic [ID_W-1:0]   drv_item_id;
   logic [DATA_W-1:0] drv_item_data;
   logic              drv_done = 1'b0;
   logic [DATA_W-1:0] drv_rsp_data = '0;
   logic              seq_rsp_valid;
   logic              seq_rsp_ready = 1'b0;
   logic [ID_W-1:0]   seq_rsp_id;
   logic [DATA_W-1:0] seq_rsp_data;
   logic              err_protocol;
`ifdef VIA_SEQ_ITEM_PORT_STATS_EN
   logic [15:0]       items_issued;
   logic [15:0]       items_done;
`endif

   via_seq_item_port #(.DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .seq_req_valid  (seq_req_valid),
      .seq_req_ready  (seq_req_ready),
      .seq_req_id     (seq_req_id),
      .seq_req_data   (seq_req_data),
      .drv_get        (drv_get),
      .drv_item_valid (drv_item_valid),
      .drv_item_id    (drv_item_id),
      .drv_item_data  (drv_item_data),
      .drv_done       (drv_done),
      .drv_rsp_data   (drv_rsp_data),
      .seq_rsp_valid  (seq_rsp_valid),
      .seq_rsp_ready  (seq_rsp_ready),
      .seq_rsp_id     (seq_rsp_id),
      .seq_rsp_data   (seq_rsp_data),
      .err_protocol   (err_protocol)
`ifdef VIA_SEQ_ITEM_PORT_STATS_EN
      ,
      .items_issued   (items_issued),
      .items_done     (items_done)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
      int                edge_idx;
   } rec_t;

   rec_t exp_items[$];   // accepted but not yet delivered, in push order
   rec_t exp_rsp[$];     // responses owed to the sequence side
   rec_t held_exp;
   rec_t cur_rsp;
   int   cyc = 0;
   int   tot = 0;
   int   bad = 0;
   int   get_edge = 0;
   int   get_sz = 0;
   bit   exp_err = 1'b0;
   bit   stop_push = 1'b0;
   logic prev_iv = 1'b0;
   logic prev_rv = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tot++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tot++;
      bad++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   // Record every accepted push together with the index of the edge that took it.
   initial forever begin
      @(posedge clk);
      if (rst_n && seq_req_valid && seq_req_ready)
         exp_items.push_back('{seq_req_id, seq_req_data, cyc});
      cyc++;
   end

   // Monitor: compares delivered items and returned responses against the scoreboard.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         prev_iv = 1'b0;
         prev_rv = 1'b0;
      end else begin
         if (drv_item_valid && !prev_iv) begin
            if (exp_items.size() == 0) begin
               tot++;
               bad++;
               $display("FAIL item_unexpected: got id %0h expected none", drv_item_id);
            end else begin
               held_exp = exp_items.pop_front();
               chk("item_id", 64'(drv_item_id), 64'(held_exp.id));
               chk("item_data", 64'(drv_item_data), 64'(held_exp.data));
               chk("item_latency", 64'(cyc),
                   64'((get_sz > 0) ? get_edge + 1 : held_exp.edge_idx + 2));
            end
         end else if (drv_item_valid) begin
            chk("item_hold_id", 64'(drv_item_id), 64'(held_exp.id));
            chk("item_hold_data", 64'(drv_item_data), 64'(held_exp.data));
         end
         chk("req_ready", 64'(seq_req_ready), 64'(exp_items.size() < DEPTH));
         if (seq_rsp_valid && !prev_rv) begin
            if (exp_rsp.size() == 0) begin
               tot++;
               bad++;
               $display("FAIL rsp_unexpected: got id %0h expected none", seq_rsp_id);
            end else begin
               cur_rsp = exp_rsp.pop_front();
               chk("rsp_id", 64'(seq_rsp_id), 64'(cur_rsp.id));
               chk("rsp_data", 64'(seq_rsp_data), 64'(cur_rsp.data));
               chk("rsp_latency", 64'(cyc), 64'(cur_rsp.edge_idx + 1));
               chk("item_drop", 64'(drv_item_valid), 64'(0));
            end
         end else if (seq_rsp_valid) begin
            chk("rsp_hold_id", 64'(seq_rsp_id), 64'(cur_rsp.id));
            chk("rsp_hold_data", 64'(seq_rsp_data), 64'(cur_rsp.data));
         end
         chk("err_protocol", 64'(err_protocol), 64'(exp_err));
         prev_iv = drv_item_valid;
         prev_rv = seq_rsp_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_item(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] data);
      int n = 0;
      seq_req_valid = 1'b1;
      seq_req_id    = id;
      seq_req_data  = data;
      @(negedge clk);
      while (!seq_req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!seq_req_ready) fail_now("push_timeout");
      tick();
      seq_req_valid = 1'b0;
   endtask

   task automatic get_pulse();
      get_edge = cyc;
      get_sz   = exp_items.size();
      drv_get  = 1'b1;
      tick();
      drv_get  = 1'b0;
   endtask

   task automatic wait_item();
      int n = 0;
      while (!drv_item_valid && n < 60) begin
         tick();
         n++;
      end
      if (!drv_item_valid) fail_now("item_timeout");
      tick();
   endtask

   task automatic finish_item(input logic [DATA_W-1:0] rsp, input int stall);
      int n = 0;
      int held = 0;
      exp_rsp.push_back('{held_exp.id, rsp, cyc});
      drv_rsp_data = rsp;
      drv_done     = 1'b1;
      tick();
      drv_done     = 1'b0;
      while (!seq_rsp_valid && n < 20) begin
         tick();
         n++;
      end
      if (!seq_rsp_valid) fail_now("rsp_timeout");
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         if (seq_rsp_valid) held++;
         tick();
      end
      if (stall > 0) chk("rsp_stall_held", 64'(held), 64'(stall));
      seq_rsp_ready = 1'b1;
      tick();
      seq_rsp_ready = 1'b0;
      chk("rsp_release", 64'(seq_rsp_valid), 64'(0));
   endtask

   task automatic transaction(input logic [DATA_W-1:0] rsp, input int stall);
      get_pulse();
      wait_item();
      finish_item(rsp, stall);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      chk("reset_item_valid", 64'(drv_item_valid), 64'(0));
      chk("reset_rsp_valid", 64'(seq_rsp_valid), 64'(0));
      chk("reset_err", 64'(err_protocol), 64'(0));
      chk("reset_item_data", 64'(drv_item_data), 64'(0));
      chk("reset_rsp_id", 64'(seq_rsp_id), 64'(0));
      rst_n = 1'b1;
      tick();
      chk("reset_ready", 64'(seq_req_ready), 64'(1));

      // Item queued before the request: delivered the cycle after drv_get.
      push_item(4'd1, 32'hA5);
      transaction(32'h11, 0);

      // Request on an empty FIFO, item arrives three cycles later.
      get_pulse();
      repeat (3) tick();
      push_item(4'd3, 32'h3333);
      wait_item();
      finish_item(32'h22, 1);

      // Fill to full, then one pop reopens the push side.
      for (int i = 0; i < 4; i++) push_item(ID_W'(i + 8), DATA_W'(32'h100 + i));
      @(negedge clk);
      chk("full_ready_low", 64'(seq_req_ready), 64'(0));
      tick();
      get_pulse();
      @(negedge clk);
      chk("pop_ready_high", 64'(seq_req_ready), 64'(1));
      tick();
      wait_item();
      finish_item(32'h33, 0);
      for (int i = 0; i < 3; i++) transaction(DATA_W'($urandom), 0);

      // Long response back-pressure.
      push_item(4'd5, 32'h55);
      get_pulse();
      wait_item();
      finish_item(32'h1234, 5);

      // Randomized sequence traffic against a protocol-abiding driver.
      fork
         begin
            while (!stop_push) begin
               seq_req_valid = ($urandom_range(0, 2) == 0);
               seq_req_id    = ID_W'($urandom);
               seq_req_data  = DATA_W'($urandom);
               tick();
            end
            seq_req_valid = 1'b0;
         end
         begin
            for (int t = 0; t < 40; t++) begin
               repeat ($urandom_range(0, 3)) tick();
               get_pulse();
               wait_item();
               repeat ($urandom_range(0, 3)) tick();
               finish_item(DATA_W'($urandom), int'($urandom_range(0, 3)));
            end
            stop_push = 1'b1;
         end
      join
      tick();
      for (int g = 0; g < 8 && exp_items.size() > 0; g++) transaction(DATA_W'($urandom), 0);

      // drv_done while idle flags an error but leaves the port usable.
      push_item(4'd6, 32'h66);
      drv_done = 1'b1;
      tick();
      drv_done = 1'b0;
      exp_err  = 1'b1;
      chk("err_set", 64'(err_protocol), 64'(1));
      repeat (3) tick();
      chk("err_sticky", 64'(err_protocol), 64'(1));
      transaction(32'h77, 0);

      // Reset while an item is held and two more are queued.
      push_item(4'd2, 32'h202);
      get_pulse();
      wait_item();
      push_item(4'd4, 32'h404);
      push_item(4'd6, 32'h606);
      rst_n = 1'b0;
      #1;
      chk("rst_item_valid", 64'(drv_item_valid), 64'(0));
      chk("rst_rsp_valid", 64'(seq_rsp_valid), 64'(0));
      chk("rst_err", 64'(err_protocol), 64'(0));
      chk("rst_item_id", 64'(drv_item_id), 64'(0));
      exp_items.delete();
      exp_rsp.delete();
      exp_err = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk("rst_ready", 64'(seq_req_ready), 64'(1));
      repeat (6) tick();
      get_pulse();
      repeat (2) tick();
      push_item(4'd7, 32'h707);
      wait_item();
      finish_item(32'h7070, 0);

      // Extra drv_get while active: error only, held item and queue untouched.
      push_item(4'd8, 32'h808);
      get_pulse();
      wait_item();
      push_item(4'd9, 32'h909);
      drv_get = 1'b1;
      tick();
      drv_get = 1'b0;
      exp_err = 1'b1;
      chk("err_get_active", 64'(err_protocol), 64'(1));
      chk("active_item_kept", 64'(drv_item_id), 64'(8));
      finish_item(32'h8080, 2);
      transaction(32'h9090, 0);
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

endmodule
